// File: rtl/sprite_lane_shifter.sv
// -----------------------------------------------------------------------------
// sprite_lane_shifter
//
// Multi-lane sprite shift pipeline for the punch game. Each lane is a row of
// DEPTH display cells. Sprites enter at the far cell (DEPTH-1) and march one
// cell toward the player (cell 0) on every shift. A punch at cell 0 removes
// the sprite there and scores a hit. A sprite that is shifted out of cell 0
// without being punched scores a miss. A small game-state FSM
// (IDLE / RUN / OVER) gates all activity and ends the game once the miss
// count reaches MISS_LIMIT.
//
// Parameters
//   LANES       number of independent lanes (rows)
//   DEPTH       cells per lane, cell 0 is nearest the player
//   PIX_W       bits per cell image
//   CNT_W       width of the hit / miss counters
//   MISS_LIMIT  misses that end the game (1 .. 2^CNT_W-1)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        IDLE -> RUN request
//   clear        OVER -> IDLE request; in IDLE or OVER also zeroes counters
//   shift        advance every lane by one cell (RUN only)
//   spawn_mask   bit l: lane l loads lane_sprite[l] into cell DEPTH-1 on shift
//   lane_sprite  sprite image per lane, lane l at [l*PIX_W +: PIX_W]
//   punch_valid  punch strobe
//   punch_lane   lane being punched (values >= LANES are ignored)
//   cell_pix     lane l cell d image at [(l*DEPTH+d)*PIX_W +: PIX_W]
//   occ          lane l cell d occupancy at bit l*DEPTH+d
//   hit          one-cycle pulse, a punch removed a sprite
//   miss         one-cycle pulse, at least one occupied cell 0 left the lane
//   hit_count    saturating hit counter
//   miss_count   saturating miss counter (adds one per missing lane)
//   state        2'b00 IDLE, 2'b01 RUN, 2'b10 OVER
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module sprite_lane_shifter #(
  parameter  int LANES      = 2,
  parameter  int DEPTH      = 6,
  parameter  int PIX_W      = 160,
  parameter  int CNT_W      = 8,
  parameter  int MISS_LIMIT = 3,
  localparam int PL_W       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         shift,
  input  logic [LANES-1:0]             spawn_mask,
  input  logic [LANES*PIX_W-1:0]       lane_sprite,
  input  logic                         punch_valid,
  input  logic [PL_W-1:0]              punch_lane,
  output logic [LANES*DEPTH*PIX_W-1:0] cell_pix,
  output logic [LANES*DEPTH-1:0]       occ,
  output logic                         hit,
  output logic                         miss,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count,
  output logic [1:0]                   state
);

  localparam int NCELL = LANES * DEPTH;

  // Counter arithmetic is done 32 bits wider than the counter so that adding
  // a full popcount can never wrap before the saturation test.
  localparam int               SUM_W     = CNT_W + 32;
  localparam logic [SUM_W-1:0] CNT_MAX   = {32'd0, {CNT_W{1'b1}}};
  localparam logic [SUM_W-1:0] LIMIT_EXT = SUM_W'(MISS_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [31:0]      inc);
    logic [SUM_W-1:0] sum;
    sum = {32'd0, a} + {{CNT_W{1'b0}}, inc};
    if (sum > CNT_MAX) begin
      return CNT_MAX[CNT_W-1:0];
    end
    return sum[CNT_W-1:0];
  endfunction

  function automatic logic [31:0] popcount(input logic [LANES-1:0] v);
    logic [31:0]      n;
    logic [LANES-1:0] vv;
    n  = '0;
    vv = v;
    for (int i = 0; i < LANES; i++) begin
      n  = n + {31'd0, vv[0]};
      vv = vv >> 1;
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                     state_q, state_d;
  logic [NCELL*PIX_W-1:0]     pix_q, pix_d;
  logic [NCELL-1:0]           occ_q, occ_d;
  logic                       hit_q, hit_d;
  logic                       miss_q, miss_d;
  logic [CNT_W-1:0]           hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]           miss_cnt_q, miss_cnt_d;

  // Per-lane decode and the two candidate cell arrays for a RUN cycle:
  // sh_* is the array after a shift, pun_* is the array when only a punch
  // (or nothing) happens.
  logic [31:0]                pl_ext;
  logic [LANES-1:0]           hit_lane;
  logic [LANES-1:0]           miss_lane;
  logic [NCELL*PIX_W-1:0]     sh_pix, pun_pix;
  logic [NCELL-1:0]           sh_occ, pun_occ;

  assign pl_ext = {{(32-PL_W){1'b0}}, punch_lane};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // Punch is judged against the pre-shift cell 0; an out-of-range lane
    // number simply matches no lane.
    assign hit_lane[l]  = punch_valid && (pl_ext == l) && occ_q[l*DEPTH];
    // A punched sprite is gone before the shift, so it cannot also miss.
    assign miss_lane[l] = shift && occ_q[l*DEPTH] && !hit_lane[l];

    for (genvar d = 0; d < DEPTH; d++) begin : g_cell
      if (d < DEPTH-1) begin : g_mid
        assign sh_pix[(l*DEPTH+d)*PIX_W +: PIX_W] =
               pix_q[(l*DEPTH+d+1)*PIX_W +: PIX_W];
        assign sh_occ[l*DEPTH+d] = occ_q[l*DEPTH+d+1];
      end else begin : g_tail
        // With DEPTH=1 this is also cell 0: the outgoing sprite was already
        // judged via miss_lane above, so loading over it here is safe.
        assign sh_pix[(l*DEPTH+d)*PIX_W +: PIX_W] =
               spawn_mask[l] ? lane_sprite[l*PIX_W +: PIX_W] : {PIX_W{1'b0}};
        assign sh_occ[l*DEPTH+d] = spawn_mask[l];
      end

      if (d == 0) begin : g_front
        assign pun_pix[(l*DEPTH+d)*PIX_W +: PIX_W] =
               hit_lane[l] ? {PIX_W{1'b0}} : pix_q[(l*DEPTH+d)*PIX_W +: PIX_W];
        assign pun_occ[l*DEPTH+d] = occ_q[l*DEPTH+d] && !hit_lane[l];
      end else begin : g_back
        assign pun_pix[(l*DEPTH+d)*PIX_W +: PIX_W] =
               pix_q[(l*DEPTH+d)*PIX_W +: PIX_W];
        assign pun_occ[l*DEPTH+d] = occ_q[l*DEPTH+d];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    occ_d      = occ_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        pix_d = '0;
        occ_d = '0;
        if (clear) begin
          hit_cnt_d  = '0;
          miss_cnt_d = '0;
        end
        if (start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (shift) begin
          pix_d = sh_pix;
          occ_d = sh_occ;
        end else begin
          pix_d = pun_pix;
          occ_d = pun_occ;
        end
        hit_d  = |hit_lane;
        miss_d = |miss_lane;
        if (hit_d) begin
          hit_cnt_d = sat_add(hit_cnt_q, 32'd1);
        end
        miss_cnt_d = sat_add(miss_cnt_q, popcount(miss_lane));
        // Game ends on the same edge as the final miss; the board is wiped
        // at that edge so OVER always shows an empty field.
        if ({32'd0, miss_cnt_d} >= LIMIT_EXT) begin
          state_d = ST_OVER;
          pix_d   = '0;
          occ_d   = '0;
        end
      end

      ST_OVER: begin
        pix_d = '0;
        occ_d = '0;
        if (clear) begin
          state_d    = ST_IDLE;
          hit_cnt_d  = '0;
          miss_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        pix_d   = '0;
        occ_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pix_q      <= '0;
      occ_q      <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      occ_q      <= occ_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign cell_pix   = pix_q;
  assign occ        = occ_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_sprite_lane_shifter.sv
// -----------------------------------------------------------------------------
// Testbench for sprite_lane_shifter. Two instances share the control inputs:
//   A: LANES=2, DEPTH=4, PIX_W=8, CNT_W=8, MISS_LIMIT=3
//   B: LANES=3, DEPTH=1, PIX_W=8, CNT_W=2, MISS_LIMIT=3
// A behavioural model of the game (per-lane cell arrays) runs alongside.
// -----------------------------------------------------------------------------
module tb_sprite_lane_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, clear, shift, punch_valid;
  logic [2:0]  spawn_mask;
  logic [23:0] lane_sprite;
  logic [1:0]  punch_lane;

  logic [63:0] pix_a;
  logic [7:0]  occ_a, hc_a, mc_a;
  logic        hit_a, miss_a;
  logic [1:0]  st_a;

  logic [23:0] pix_b;
  logic [2:0]  occ_b;
  logic        hit_b, miss_b;
  logic [1:0]  hc_b, mc_b, st_b;

  logic [91:0] act_a;
  logic [34:0] act_b;
  assign act_a = {pix_a, occ_a, hit_a, miss_a, hc_a, mc_a, st_a};
  assign act_b = {pix_b, occ_b, hit_b, miss_b, hc_b, mc_b, st_b};

  sprite_lane_shifter #(.LANES(2), .DEPTH(4), .PIX_W(8), .CNT_W(8), .MISS_LIMIT(3)) dut_a (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .shift(shift),
    .spawn_mask(spawn_mask[1:0]), .lane_sprite(lane_sprite[15:0]),
    .punch_valid(punch_valid), .punch_lane(punch_lane[0:0]),
    .cell_pix(pix_a), .occ(occ_a), .hit(hit_a), .miss(miss_a),
    .hit_count(hc_a), .miss_count(mc_a), .state(st_a)
  );

  sprite_lane_shifter #(.LANES(3), .DEPTH(1), .PIX_W(8), .CNT_W(2), .MISS_LIMIT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .shift(shift),
    .spawn_mask(spawn_mask), .lane_sprite(lane_sprite),
    .punch_valid(punch_valid), .punch_lane(punch_lane),
    .cell_pix(pix_b), .occ(occ_b), .hit(hit_b), .miss(miss_b),
    .hit_count(hc_b), .miss_count(mc_b), .state(st_b)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: k=0 mirrors instance A, k=1 instance B.
  int         m_st [2];
  int         m_hc [2];
  int         m_mc [2];
  bit         m_hit[2];
  bit         m_miss[2];
  logic [7:0] m_pix[2][3][4];
  bit         m_occ[2][3][4];

  task automatic zero_cells(input int k);
    for (int l = 0; l < 3; l++)
      for (int d = 0; d < 4; d++) begin
        m_pix[k][l][d] = 8'h00;
        m_occ[k][l][d] = 1'b0;
      end
  endtask

  task automatic model_upd(input int k);
    int nl, nd, mx, pl, nm;
    nl = (k == 0) ? 2 : 3;
    nd = (k == 0) ? 4 : 1;
    mx = (k == 0) ? 255 : 3;
    pl = (k == 0) ? int'(punch_lane[0]) : int'(punch_lane);
    m_hit[k]  = 1'b0;
    m_miss[k] = 1'b0;
    if (rst) begin
      m_st[k] = 0; m_hc[k] = 0; m_mc[k] = 0;
      zero_cells(k);
      return;
    end
    case (m_st[k])
      0: begin
        if (clear) begin m_hc[k] = 0; m_mc[k] = 0; end
        if (start) m_st[k] = 1;
      end
      1: begin
        if (punch_valid && pl < nl && m_occ[k][pl][0]) begin
          m_hit[k] = 1'b1;
          m_hc[k]  = (m_hc[k] + 1 > mx) ? mx : m_hc[k] + 1;
          m_occ[k][pl][0] = 1'b0;
          m_pix[k][pl][0] = 8'h00;
        end
        if (shift) begin
          nm = 0;
          for (int l = 0; l < nl; l++) begin
            if (m_occ[k][l][0]) nm++;
            for (int d = 0; d < nd - 1; d++) begin
              m_pix[k][l][d] = m_pix[k][l][d+1];
              m_occ[k][l][d] = m_occ[k][l][d+1];
            end
            m_pix[k][l][nd-1] = spawn_mask[l] ? lane_sprite[l*8 +: 8] : 8'h00;
            m_occ[k][l][nd-1] = spawn_mask[l];
          end
          m_miss[k] = (nm > 0);
          m_mc[k]   = (m_mc[k] + nm > mx) ? mx : m_mc[k] + nm;
        end
        if (m_mc[k] >= 3) begin
          m_st[k] = 2;
          zero_cells(k);
        end
      end
      default: begin
        if (clear) begin m_st[k] = 0; m_hc[k] = 0; m_mc[k] = 0; end
      end
    endcase
  endtask

  function automatic logic [91:0] exp_a();
    logic [63:0] p;
    logic [7:0]  o;
    for (int l = 0; l < 2; l++)
      for (int d = 0; d < 4; d++) begin
        p[(l*4+d)*8 +: 8] = m_pix[0][l][d];
        o[l*4+d]          = m_occ[0][l][d];
      end
    return {p, o, m_hit[0], m_miss[0], 8'(m_hc[0]), 8'(m_mc[0]), 2'(m_st[0])};
  endfunction

  function automatic logic [34:0] exp_b();
    logic [23:0] p;
    logic [2:0]  o;
    for (int l = 0; l < 3; l++) begin
      p[l*8 +: 8] = m_pix[1][l][0];
      o[l]        = m_occ[1][l][0];
    end
    return {p, o, m_hit[1], m_miss[1], 2'(m_hc[1]), 2'(m_mc[1]), 2'(m_st[1])};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_upd(0);
    model_upd(1);
    #1;
  endtask

  task automatic idle_in();
    rst = 0; start = 0; clear = 0; shift = 0; punch_valid = 0;
    spawn_mask = '0; lane_sprite = '0; punch_lane = '0;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1; start = 1; shift = 1; spawn_mask = 3'b111;
    lane_sprite = 24'hFFFFFF; punch_valid = 1;
    tick();
    nvec++; if (act_a !== 92'd0) begin nerr++; $display("FAIL reset_a: got %h want 0", act_a); end
    nvec++; if (act_b !== 35'd0) begin nerr++; $display("FAIL reset_b: got %h want 0", act_b); end
    idle_in();
    tick();
    nvec++; if (st_a !== 2'b00) begin nerr++; $display("FAIL reset_idle_hold: state=%b want 00", st_a); end
  endtask

  task automatic test_march();
    start = 1; tick(); start = 0;
    nvec++; if (st_a !== 2'b01) begin nerr++; $display("FAIL start_run_a: state=%b want 01", st_a); end
    nvec++; if (st_b !== 2'b01) begin nerr++; $display("FAIL start_run_b: state=%b want 01", st_b); end
    shift = 1; spawn_mask = 3'b001; lane_sprite = 24'h0000A5;
    tick();
    nvec++; if (pix_a[31:24] !== 8'hA5 || occ_a !== 8'h08) begin
      nerr++; $display("FAIL spawn_cell3: pix=%h occ=%h want A5/08", pix_a[31:24], occ_a); end
    nvec++; if (pix_b[7:0] !== 8'hA5 || occ_b !== 3'b001) begin
      nerr++; $display("FAIL spawn_depth1: pix=%h occ=%b want A5/001", pix_b[7:0], occ_b); end
    spawn_mask = '0; lane_sprite = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++; if (hit_a !== 1'b0 || miss_a !== 1'b0) begin
        nerr++; $display("FAIL march_pulse: hit=%b miss=%b want 0/0", hit_a, miss_a); end
      if (i == 0) begin
        nvec++; if (miss_b !== 1'b1 || mc_b !== 2'd1 || occ_b !== 3'b000) begin
          nerr++; $display("FAIL depth1_exit: miss=%b cnt=%0d occ=%b want 1/1/000", miss_b, mc_b, occ_b); end
      end
    end
    nvec++; if (pix_a[7:0] !== 8'hA5 || occ_a !== 8'h01) begin
      nerr++; $display("FAIL reach_cell0: pix=%h occ=%h want A5/01", pix_a[7:0], occ_a); end
    tick();
    nvec++; if (miss_a !== 1'b1 || mc_a !== 8'd1 || pix_a !== 64'd0 || occ_a !== 8'h00 || st_a !== 2'b01) begin
      nerr++; $display("FAIL exit_miss: miss=%b cnt=%0d pix=%h occ=%h st=%b want 1/1/0/0/01", miss_a, mc_a, pix_a, occ_a, st_a); end
    shift = 0; tick();
    nvec++; if (miss_a !== 1'b0 || mc_a !== 8'd1) begin
      nerr++; $display("FAIL miss_one_cycle: miss=%b cnt=%0d want 0/1", miss_a, mc_a); end
    nvec++; if (act_a !== exp_a()) begin nerr++; $display("FAIL march_model_a: got %h want %h", act_a, exp_a()); end
    nvec++; if (act_b !== exp_b()) begin nerr++; $display("FAIL march_model_b: got %h want %h", act_b, exp_b()); end
  endtask

  task automatic test_punch_shift();
    shift = 1; spawn_mask = 3'b010; lane_sprite = 24'h003C00; tick();
    lane_sprite = 24'h007700; tick();
    spawn_mask = '0; lane_sprite = '0; tick(); tick();
    nvec++; if (pix_a[39:32] !== 8'h3C || pix_a[47:40] !== 8'h77 || occ_a !== 8'h30) begin
      nerr++; $display("FAIL lane1_setup: c0=%h c1=%h occ=%h want 3C/77/30", pix_a[39:32], pix_a[47:40], occ_a); end
    punch_valid = 1; punch_lane = 2'd1; shift = 1; tick();
    nvec++; if (hit_a !== 1'b1 || miss_a !== 1'b0 || hc_a !== 8'd1 || mc_a !== 8'd1) begin
      nerr++; $display("FAIL punch_shift_pulse: hit=%b miss=%b hc=%0d mc=%0d want 1/0/1/1", hit_a, miss_a, hc_a, mc_a); end
    nvec++; if (pix_a[39:32] !== 8'h77 || occ_a !== 8'h10) begin
      nerr++; $display("FAIL punch_shift_cells: c0=%h occ=%h want 77/10", pix_a[39:32], occ_a); end
    punch_valid = 0; shift = 0; tick();
    nvec++; if (hit_a !== 1'b0 || hc_a !== 8'd1) begin
      nerr++; $display("FAIL hit_one_cycle: hit=%b hc=%0d want 0/1", hit_a, hc_a); end
    nvec++; if (act_b !== exp_b()) begin nerr++; $display("FAIL punch_model_b: got %h want %h", act_b, exp_b()); end
  endtask

  task automatic test_over();
    punch_valid = 1; punch_lane = 2'd1; tick(); punch_valid = 0;
    nvec++; if (hit_a !== 1'b1 || hc_a !== 8'd2 || occ_a !== 8'h00) begin
      nerr++; $display("FAIL punch_noshift: hit=%b hc=%0d occ=%h want 1/2/00", hit_a, hc_a, occ_a); end
    shift = 1; spawn_mask = 3'b011; lane_sprite = 24'h002211; tick();
    spawn_mask = '0; lane_sprite = '0; tick(); tick(); tick();
    nvec++; if (occ_a !== 8'h11 || pix_a[7:0] !== 8'h11 || pix_a[39:32] !== 8'h22 || mc_a !== 8'd1) begin
      nerr++; $display("FAIL both_front: occ=%h c00=%h c10=%h mc=%0d want 11/11/22/1", occ_a, pix_a[7:0], pix_a[39:32], mc_a); end
    tick();
    nvec++; if (miss_a !== 1'b1 || mc_a !== 8'd3 || st_a !== 2'b10 || pix_a !== 64'd0 || occ_a !== 8'h00) begin
      nerr++; $display("FAIL game_over: miss=%b mc=%0d st=%b pix=%h occ=%h want 1/3/10/0/0", miss_a, mc_a, st_a, pix_a, occ_a); end
    start = 1; spawn_mask = 3'b011; lane_sprite = 24'h00FFFF; punch_valid = 1; punch_lane = 2'd0;
    tick(); tick();
    nvec++; if (st_a !== 2'b10 || mc_a !== 8'd3 || hc_a !== 8'd2 || occ_a !== 8'h00 || hit_a !== 1'b0 || miss_a !== 1'b0) begin
      nerr++; $display("FAIL over_frozen: st=%b mc=%0d hc=%0d occ=%h hit=%b miss=%b", st_a, mc_a, hc_a, occ_a, hit_a, miss_a); end
    idle_in(); clear = 1; tick(); clear = 0;
    nvec++; if (st_a !== 2'b00 || hc_a !== 8'd0 || mc_a !== 8'd0) begin
      nerr++; $display("FAIL clear_idle_a: st=%b hc=%0d mc=%0d want 00/0/0", st_a, hc_a, mc_a); end
    nvec++; if (st_b !== 2'b00 || hc_b !== 2'd0 || mc_b !== 2'd0) begin
      nerr++; $display("FAIL clear_idle_b: st=%b hc=%0d mc=%0d want 00/0/0", st_b, hc_b, mc_b); end
  endtask

  task automatic test_saturate();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 5; i++) begin
      shift = 1; spawn_mask = 3'b001; lane_sprite = 24'h00005A; punch_valid = 0; tick();
      shift = 0; spawn_mask = '0; punch_valid = 1; punch_lane = 2'd0; tick();
      nvec++; if (hit_b !== 1'b1) begin nerr++; $display("FAIL sat_hit_pulse: hit=%b want 1 (iter %0d)", hit_b, i); end
    end
    punch_valid = 0;
    nvec++; if (hc_b !== 2'd3) begin nerr++; $display("FAIL hit_saturate: hc=%0d want 3", hc_b); end
    nvec++; if (act_a !== exp_a()) begin nerr++; $display("FAIL sat_model_a: got %h want %h", act_a, exp_a()); end
    punch_valid = 1; punch_lane = 2'd0; tick();
    nvec++; if (hit_b !== 1'b0 || hc_b !== 2'd3) begin
      nerr++; $display("FAIL punch_empty: hit=%b hc=%0d want 0/3", hit_b, hc_b); end
    punch_valid = 0; shift = 1; spawn_mask = 3'b111; lane_sprite = 24'h123456; tick();
    shift = 0; spawn_mask = '0; punch_valid = 1; punch_lane = 2'd3; tick();
    nvec++; if (hit_b !== 1'b0 || occ_b !== 3'b111 || hc_b !== 2'd3) begin
      nerr++; $display("FAIL punch_bad_lane: hit=%b occ=%b hc=%0d want 0/111/3", hit_b, occ_b, hc_b); end
    nvec++; if (act_a !== exp_a()) begin nerr++; $display("FAIL badlane_model_a: got %h want %h", act_a, exp_a()); end
  endtask

  task automatic test_reset_midrun();
    rst = 1; shift = 1; punch_valid = 1; punch_lane = 2'd0; spawn_mask = 3'b111; lane_sprite = 24'hABCDEF;
    tick();
    nvec++; if (act_a !== 92'd0) begin nerr++; $display("FAIL midrun_reset_a: got %h want 0", act_a); end
    nvec++; if (act_b !== 35'd0) begin nerr++; $display("FAIL midrun_reset_b: got %h want 0", act_b); end
    idle_in(); shift = 1; spawn_mask = 3'b011; tick();
    nvec++; if (st_a !== 2'b00 || occ_a !== 8'h00) begin
      nerr++; $display("FAIL idle_ignores_shift: st=%b occ=%h want 00/00", st_a, occ_a); end
    idle_in();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(63) == 0);
      start       = ($urandom_range(7) == 0);
      clear       = ($urandom_range(15) == 0);
      shift       = 1'($urandom_range(1));
      spawn_mask  = 3'($urandom);
      lane_sprite = 24'($urandom);
      punch_valid = 1'($urandom_range(1));
      punch_lane  = 2'($urandom);
      tick();
      nvec++; if (act_a !== exp_a()) begin nerr++; $display("FAIL random_a cyc %0d: got %h want %h", i, act_a, exp_a()); end
      nvec++; if (act_b !== exp_b()) begin nerr++; $display("FAIL random_b cyc %0d: got %h want %h", i, act_b, exp_b()); end
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_hc[k] = 0; m_mc[k] = 0; m_hit[k] = 0; m_miss[k] = 0;
      zero_cells(k);
    end
    test_reset();
    test_march();
    test_punch_shift();
    test_over();
    test_saturate();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
